// File: rtl/prog_loader.sv
// prog_loader: streams a program image into memory, then supervises the run.
//   start/in_valid/in_data/in_last/in_ready : image stream, accepted only in LOAD
//   com_data_in/com_addr/com_wr_en           : registered memory write port
//   status (00 load/idle, 01 run, 10 done, 11 error), end_process from processor
//   words_loaded, checksum                   : progress of the current load
// Optional checksum adder: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] com_data_in,
  output logic [ADDR_W-1:0] com_addr,
  output logic              com_wr_en,
  output logic [1:0]        status,
  input  logic              end_process,
  output logic [ADDR_W:0]   words_loaded,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        status_q, status_d;
  logic              com_wr_en_q, com_wr_en_d;
  logic [DATA_W-1:0] com_data_in_q, com_data_in_d;
  logic [ADDR_W-1:0] com_addr_q, com_addr_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic [31:0]       run_cnt_q, run_cnt_d;
  logic              clr_d;
  logic              xfer;

  function automatic logic [1:0] status_of(input state_e s);
    case (s)
      S_RUN:   return 2'b01;
      S_DONE:  return 2'b10;
      S_ERR:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  assign xfer = in_valid && (state_q == S_LOAD);

  always_comb begin
    state_d        = state_q;
    com_wr_en_d    = 1'b0;
    com_data_in_d  = com_data_in_q;
    com_addr_d     = com_addr_q;
    words_loaded_d = words_loaded_q;
    run_cnt_d      = '0;
    clr_d          = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d        = S_LOAD;
          words_loaded_d = '0;
          clr_d          = 1'b1;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (words_loaded_q == DEPTH_W) begin
            state_d = S_ERR;
          end else begin
            com_wr_en_d    = 1'b1;
            com_data_in_d  = in_data;
            com_addr_d     = BASE_ADDR + words_loaded_q[ADDR_W-1:0];
            words_loaded_d = words_loaded_q + 1'b1;
            if (in_last) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_RUN;
      S_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        // end_process is checked first so it wins over a same-cycle timeout
        if (end_process) begin
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (run_cnt_q == TIMEOUT - 1)) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // status is registered from the next state so it tracks state_q exactly
    status_d = status_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      status_q       <= 2'b00;
      com_wr_en_q    <= 1'b0;
      com_data_in_q  <= '0;
      com_addr_q     <= '0;
      words_loaded_q <= '0;
      run_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      status_q       <= status_d;
      com_wr_en_q    <= com_wr_en_d;
      com_data_in_q  <= com_data_in_d;
      com_addr_q     <= com_addr_d;
      words_loaded_q <= words_loaded_d;
      run_cnt_q      <= run_cnt_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (clr_d) begin
      checksum_d = '0;
    end else if (com_wr_en_d) begin
      checksum_d = checksum_q + in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign in_ready     = (state_q == S_LOAD);
  assign status       = status_q;
  assign com_wr_en    = com_wr_en_q;
  assign com_data_in  = com_data_in_q;
  assign com_addr     = com_addr_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]       start, in_valid, in_last, in_ready, com_wr_en, end_process;
  logic [1:0][15:0] in_data, com_data_in, com_addr, checksum;
  logic [1:0][1:0]  status;
  logic [1:0][16:0] words_loaded;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  wr_t         exp_q [2][$];
  logic [16:0] words_model [2];
  logic [15:0] chk_model   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: base 0, depth 1024, no timeout
  prog_loader #(
    .DATA_W(16), .ADDR_W(16), .BASE_ADDR(16'h0000), .DEPTH(1024), .TIMEOUT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]),
    .in_data(in_data[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
    .com_data_in(com_data_in[0]), .com_addr(com_addr[0]), .com_wr_en(com_wr_en[0]),
    .status(status[0]), .end_process(end_process[0]),
    .words_loaded(words_loaded[0]), .checksum(checksum[0])
  );

  // dut1: base 65534 (wraps), depth 4, timeout 8
  prog_loader #(
    .DATA_W(16), .ADDR_W(16), .BASE_ADDR(16'hFFFE), .DEPTH(4), .TIMEOUT(8)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]),
    .in_data(in_data[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
    .com_data_in(com_data_in[1]), .com_addr(com_addr[1]), .com_wr_en(com_wr_en[1]),
    .status(status[1]), .end_process(end_process[1]),
    .words_loaded(words_loaded[1]), .checksum(checksum[1])
  );

  function automatic logic [15:0] base_of(input int sel);
    return (sel == 0) ? 16'h0000 : 16'hFFFE;
  endfunction

  // Write-port scoreboard: every write must match the head entry on its due cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit due;
      due = (exp_q[d].size() > 0) && (exp_q[d][0].cyc == cyc);
      if ((com_wr_en[d] === 1'b1) || due) begin
        checks++;
        if (!due)
          $display("FAIL unexpected_write dut%0d cyc=%0d: got addr=%0d data=%0d, required no write",
                   d, cyc, com_addr[d], com_data_in[d]);
        else if (com_wr_en[d] !== 1'b1)
          $display("FAIL missing_write dut%0d cyc=%0d: got wr_en=%b, required write addr=%0d data=%0d",
                   d, cyc, com_wr_en[d], exp_q[d][0].addr, exp_q[d][0].data);
        else if (com_addr[d] !== exp_q[d][0].addr || com_data_in[d] !== exp_q[d][0].data)
          $display("FAIL write_value dut%0d cyc=%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   d, cyc, com_addr[d], com_data_in[d], exp_q[d][0].addr, exp_q[d][0].data);
        else
          passed++;
        if (due) void'(exp_q[d].pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int sel);
    start[sel] = 1'b1;
    words_model[sel] = '0;
    chk_model[sel]   = '0;
    tick();
    start[sel] = 1'b0;
  endtask

  task automatic pulse_end(input int sel);
    end_process[sel] = 1'b1;
    tick();
    end_process[sel] = 1'b0;
  endtask

  task automatic send(input int sel, input logic [15:0] d, input logic last, input bit accept);
    in_valid[sel] = 1'b1;
    in_data[sel]  = d;
    in_last[sel]  = last;
    if (accept) begin
      exp_q[sel].push_back('{cyc: cyc + 1, addr: base_of(sel) + words_model[sel][15:0], data: d});
      words_model[sel] = words_model[sel] + 1'b1;
      chk_model[sel]   = chk_model[sel] + d;
    end
    tick();
    in_valid[sel] = 1'b0;
    in_last[sel]  = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (status[d] !== 2'b00 || com_wr_en[d] !== 1'b0 || com_addr[d] !== 16'd0 ||
          com_data_in[d] !== 16'd0 || words_loaded[d] !== 17'd0 || checksum[d] !== 16'd0 ||
          in_ready[d] !== 1'b0)
        $display("FAIL reset_values dut%0d: got st=%b we=%b a=%0d d=%0d wl=%0d ck=%0d rdy=%b, required all zero",
                 d, status[d], com_wr_en[d], com_addr[d], com_data_in[d], words_loaded[d],
                 checksum[d], in_ready[d]);
      else passed++;
    end
  endtask

  task automatic test_basic_load();
    pulse_start(0);
    checks++;
    if (in_ready[0] !== 1'b1 || status[0] !== 2'b00 || words_loaded[0] !== 17'd0)
      $display("FAIL load_entry: got rdy=%b st=%b wl=%0d, required rdy=1 st=00 wl=0",
               in_ready[0], status[0], words_loaded[0]);
    else passed++;
    send(0, 16'd10, 1'b0, 1'b1);
    send(0, 16'd20, 1'b0, 1'b1);
    send(0, 16'd30, 1'b1, 1'b1);
    // final write visible now; status must not be 01 yet
    checks++;
    if (status[0] !== 2'b00)
      $display("FAIL drain_status: got %b, required 00", status[0]);
    else passed++;
    tick();
    checks++;
    if (status[0] !== 2'b01 || in_ready[0] !== 1'b0)
      $display("FAIL run_status: got st=%b rdy=%b, required st=01 rdy=0", status[0], in_ready[0]);
    else passed++;
    checks++;
    if (words_loaded[0] !== words_model[0] || checksum[0] !== (CHK_EN ? chk_model[0] : 16'd0))
      $display("FAIL basic_counts: got wl=%0d ck=%0d, required wl=%0d ck=%0d", words_loaded[0],
               checksum[0], words_model[0], CHK_EN ? chk_model[0] : 16'd0);
    else passed++;
  endtask

  task automatic test_run_done_reload();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    checks++;
    if (status[0] !== 2'b01 || words_loaded[0] !== 17'd3)
      $display("FAIL start_in_run: got st=%b wl=%0d, required st=01 wl=3", status[0], words_loaded[0]);
    else passed++;
    pulse_end(0);
    checks++;
    if (status[0] !== 2'b10)
      $display("FAIL done_status: got %b, required 10", status[0]);
    else passed++;
    pulse_start(0);
    checks++;
    if (status[0] !== 2'b00 || words_loaded[0] !== 17'd0 || checksum[0] !== 16'd0 || in_ready[0] !== 1'b1)
      $display("FAIL reload_entry: got st=%b wl=%0d ck=%0d rdy=%b, required 00/0/0/1",
               status[0], words_loaded[0], checksum[0], in_ready[0]);
    else passed++;
    // stall with end_process asserted outside RUN: nothing may change
    end_process[0] = 1'b1;
    tick();
    tick();
    end_process[0] = 1'b0;
    checks++;
    if (status[0] !== 2'b00 || words_loaded[0] !== 17'd0 || in_ready[0] !== 1'b1)
      $display("FAIL stall: got st=%b wl=%0d rdy=%b, required 00/0/1", status[0], words_loaded[0], in_ready[0]);
    else passed++;
    send(0, 16'd5, 1'b0, 1'b1);
    send(0, 16'd7, 1'b1, 1'b1);
    tick();
    checks++;
    if (status[0] !== 2'b01 || words_loaded[0] !== words_model[0] ||
        checksum[0] !== (CHK_EN ? chk_model[0] : 16'd0))
      $display("FAIL reload_done: got st=%b wl=%0d ck=%0d, required st=01 wl=%0d ck=%0d", status[0],
               words_loaded[0], checksum[0], words_model[0], CHK_EN ? chk_model[0] : 16'd0);
    else passed++;
  endtask

  task automatic test_wrap_timeout();
    pulse_start(1);
    send(1, 16'hA001, 1'b0, 1'b1);
    send(1, 16'hA002, 1'b0, 1'b1);
    send(1, 16'hA003, 1'b0, 1'b1);
    send(1, 16'hA004, 1'b1, 1'b1);
    tick();
    checks++;
    if (status[1] !== 2'b01 || words_loaded[1] !== 17'd4)
      $display("FAIL full_depth_done: got st=%b wl=%0d, required st=01 wl=4", status[1], words_loaded[1]);
    else passed++;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (status[1] !== 2'b01)
      $display("FAIL pre_timeout: got %b, required 01", status[1]);
    else passed++;
    tick();
    checks++;
    if (status[1] !== 2'b11 || in_ready[1] !== 1'b0)
      $display("FAIL timeout: got st=%b rdy=%b, required st=11 rdy=0", status[1], in_ready[1]);
    else passed++;
  endtask

  task automatic test_overflow();
    pulse_start(1);
    for (int i = 0; i < 4; i++) send(1, 16'(16'h0B00 + i), 1'b0, 1'b1);
    send(1, 16'h0BFF, 1'b0, 1'b0);
    checks++;
    if (status[1] !== 2'b11 || in_ready[1] !== 1'b0 || words_loaded[1] !== 17'd4)
      $display("FAIL overflow: got st=%b rdy=%b wl=%0d, required st=11 rdy=0 wl=4",
               status[1], in_ready[1], words_loaded[1]);
    else passed++;
    tick();
    tick();
  endtask

  task automatic test_timeout_priority();
    pulse_start(1);
    send(1, 16'h1234, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 7; i++) tick();
    end_process[1] = 1'b1;
    tick();
    end_process[1] = 1'b0;
    checks++;
    if (status[1] !== 2'b10)
      $display("FAIL end_vs_timeout: got %b, required 10", status[1]);
    else passed++;
  endtask

  task automatic test_reset_midload();
    pulse_end(0);
    pulse_start(0);
    send(0, 16'd100, 1'b0, 1'b1);
    send(0, 16'd200, 1'b0, 1'b1);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'd300;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_data[0] = 16'd400;
    checks++;
    if (status[0] !== 2'b00 || words_loaded[0] !== 17'd0 || in_ready[0] !== 1'b0 ||
        checksum[0] !== 16'd0)
      $display("FAIL midload_reset: got st=%b wl=%0d rdy=%b ck=%0d, required 00/0/0/0",
               status[0], words_loaded[0], in_ready[0], checksum[0]);
    else passed++;
    tick();
    tick();
    in_valid[0] = 1'b0;
    pulse_start(0);
    send(0, 16'd1, 1'b0, 1'b1);
    send(0, 16'd2, 1'b1, 1'b1);
    tick();
    checks++;
    if (status[0] !== 2'b01 || words_loaded[0] !== 17'd2)
      $display("FAIL reload_after_reset: got st=%b wl=%0d, required st=01 wl=2", status[0], words_loaded[0]);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0; in_valid = '0; in_last = '0; end_process = '0; in_data = '0;
    words_model[0] = '0; words_model[1] = '0;
    chk_model[0]   = '0; chk_model[1]   = '0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic_load();
    test_run_done_reload();
    test_wrap_timeout();
    test_overflow();
    test_timeout_priority();
    test_reset_midload();
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (exp_q[d].size() != 0)
        $display("FAIL scoreboard_drain dut%0d: got %0d pending, required 0", d, exp_q[d].size());
      else passed++;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
